// File: rtl/ahb2apb_pkg.sv
// Shared types and address map for the AHB2APB bridge.
package ahb2apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WWAIT    = 3'd1,
    ST_READ     = 3'd2,
    ST_WRITE    = 3'd3,
    ST_WRITEP   = 3'd4,
    ST_RENABLE  = 3'd5,
    ST_WENABLE  = 3'd6,
    ST_WENABLEP = 3'd7
  } state_t;

  localparam logic [31:0] SLV0_BASE = 32'h8000_0000;
  localparam logic [31:0] SLV1_BASE = 32'h8400_0000;
  localparam logic [31:0] SLV2_BASE = 32'h8800_0000;
  localparam logic [31:0] SLV_LIMIT = 32'h8c00_0000;

  localparam logic [2:0] SEL_S0 = 3'b001;
  localparam logic [2:0] SEL_S1 = 3'b010;
  localparam logic [2:0] SEL_S2 = 3'b100;

  // One-hot slave select for an address; zero outside the bridge window.
  function automatic logic [2:0] sel_decode(input logic [31:0] addr);
    if (addr >= SLV0_BASE && addr < SLV1_BASE)      return SEL_S0;
    else if (addr >= SLV1_BASE && addr < SLV2_BASE) return SEL_S1;
    else if (addr >= SLV2_BASE && addr < SLV_LIMIT) return SEL_S2;
    else                                            return 3'b000;
  endfunction

endpackage

// File: rtl/apb_controller.sv
// APB setup/enable sequencer of the AHB2APB bridge; registered APB outputs.
// Define APB_PREADY_EN to let pready stretch the ENABLE states.
module apb_controller
  import ahb2apb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NSEL   = 3
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              valid,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [ADDR_W-1:0] haddr1,
  input  logic [ADDR_W-1:0] haddr2,
  input  logic              hwrite,
  input  logic              hwrite_reg,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [NSEL-1:0]   temp_selx,
  input  logic              pready,
  output logic              penable,
  output logic              pwrite,
  output logic [NSEL-1:0]   pselx,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              hready_out
);

  state_t            state;
  state_t            state_nxt;
  logic [NSEL-1:0]   sel_d1;
  logic [NSEL-1:0]   sel_d2;
  logic [DATA_W-1:0] wdata_hold;
  logic              apb_done;
  logic              stall;

`ifdef APB_PREADY_EN
  assign apb_done = pready;
`else
  logic unused_pready;
  assign unused_pready = pready;
  assign apb_done      = 1'b1;
`endif

  assign stall = !apb_done &&
                 (state == ST_RENABLE || state == ST_WENABLE || state == ST_WENABLEP);

  // Next-state decode
  always_comb begin
    state_nxt = state;
    if (!stall) begin
      case (state)
        ST_IDLE:     state_nxt = !valid ? ST_IDLE : (hwrite ? ST_WWAIT : ST_READ);
        ST_READ:     state_nxt = ST_RENABLE;
        ST_RENABLE:  state_nxt = !valid ? ST_IDLE : (hwrite ? ST_WWAIT : ST_READ);
        ST_WWAIT:    state_nxt = valid ? ST_WRITEP : ST_WRITE;
        ST_WRITE:    state_nxt = valid ? ST_WENABLEP : ST_WENABLE;
        ST_WRITEP:   state_nxt = ST_WENABLEP;
        ST_WENABLE:  state_nxt = !valid ? ST_IDLE : (hwrite ? ST_WWAIT : ST_READ);
        ST_WENABLEP: state_nxt = !hwrite_reg ? ST_READ : (valid ? ST_WRITEP : ST_WRITE);
        default:     state_nxt = ST_IDLE;
      endcase
    end
  end

  // State and outputs take the values of the state being entered
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state      <= ST_IDLE;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      pselx      <= '0;
      paddr      <= '0;
      pwdata     <= '0;
      hready_out <= 1'b1;
      sel_d1     <= '0;
      sel_d2     <= '0;
      wdata_hold <= '0;
    end else begin
      state  <= state_nxt;
      sel_d1 <= temp_selx;
      sel_d2 <= sel_d1;
      // WENABLEP entry is the cycle the overlapped write's data sits on hwdata
      if (state_nxt != state && (state_nxt == ST_WRITEP || state_nxt == ST_WENABLEP))
        wdata_hold <= hwdata;
      if (stall) begin
        hready_out <= 1'b0;
      end else begin
        case (state_nxt)
          ST_IDLE, ST_WWAIT: begin
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            hready_out <= 1'b1;
            pselx      <= '0;
          end
          ST_READ: begin
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            hready_out <= 1'b0;
            pselx      <= temp_selx;
            paddr      <= haddr;
          end
          ST_RENABLE: begin
            penable    <= 1'b1;
            pwrite     <= 1'b0;
            hready_out <= 1'b1;
          end
          ST_WRITE, ST_WRITEP: begin
            penable    <= 1'b0;
            pwrite     <= 1'b1;
            hready_out <= 1'b0;
            if (state == ST_WENABLEP) begin
              paddr  <= haddr2;
              pselx  <= sel_d2;
              pwdata <= wdata_hold;
            end else begin
              paddr  <= haddr1;
              pselx  <= sel_d1;
              pwdata <= hwdata;
            end
          end
          ST_WENABLE: begin
            penable    <= 1'b1;
            pwrite     <= 1'b1;
            hready_out <= 1'b1;
          end
          ST_WENABLEP: begin
            penable    <= 1'b1;
            pwrite     <= 1'b1;
            hready_out <= 1'b0;
          end
          default: begin
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            hready_out <= 1'b1;
            pselx      <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_apb_controller.sv
// Directed self-checking bench for apb_controller.
module tb_apb_controller;
  import ahb2apb_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NSEL   = 3;

  logic              hclk = 1'b0;
  logic              hreset;
  logic              valid;
  logic [ADDR_W-1:0] haddr;
  logic [ADDR_W-1:0] haddr1;
  logic [ADDR_W-1:0] haddr2;
  logic              hwrite;
  logic              hwrite_reg;
  logic [DATA_W-1:0] hwdata;
  logic [NSEL-1:0]   temp_selx;
  logic              pready;
  logic              penable;
  logic              pwrite;
  logic [NSEL-1:0]   pselx;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              hready_out;

  int checks   = 0;
  int failures = 0;

  apb_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSEL(NSEL)) dut (
    .hclk       (hclk),
    .hreset     (hreset),
    .valid      (valid),
    .haddr      (haddr),
    .haddr1     (haddr1),
    .haddr2     (haddr2),
    .hwrite     (hwrite),
    .hwrite_reg (hwrite_reg),
    .hwdata     (hwdata),
    .temp_selx  (temp_selx),
    .pready     (pready),
    .penable    (penable),
    .pwrite     (pwrite),
    .pselx      (pselx),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .hready_out (hready_out)
  );

  always #5 hclk = ~hclk;

  // Upstream AHB slave pipeline model
  assign temp_selx = sel_decode(haddr);
  always_ff @(posedge hclk) begin
    if (hreset) begin
      haddr1     <= '0;
      haddr2     <= '0;
      hwrite_reg <= 1'b0;
    end else begin
      haddr1     <= haddr;
      haddr2     <= haddr1;
      hwrite_reg <= hwrite;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk_state(input string tag, input state_t exp);
    check(tag, 64'(dut.state), 64'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    hreset = 1'b1;
    valid  = 1'b0;
    haddr  = '0;
    hwrite = 1'b0;
    hwdata = '0;
`ifdef APB_PREADY_EN
    pready = 1'b1;
`else
    pready = 1'b0;
`endif
    tick();
    tick();
    chk_state("rst_state", ST_IDLE);
    check("rst_penable", 64'(penable), 64'd0);
    check("rst_pwrite", 64'(pwrite), 64'd0);
    check("rst_pselx", 64'(pselx), 64'd0);
    check("rst_paddr", 64'(paddr), 64'd0);
    check("rst_pwdata", 64'(pwdata), 64'd0);
    check("rst_hready", 64'(hready_out), 64'd1);
    hreset = 1'b0;

    // Single read
    valid = 1'b1; hwrite = 1'b0; haddr = 32'h8000_0010;
    tick();
    chk_state("rd_state_setup", ST_READ);
    check("rd_pselx", 64'(pselx), 64'h1);
    check("rd_paddr", 64'(paddr), 64'h8000_0010);
    check("rd_penable0", 64'(penable), 64'd0);
    check("rd_hready0", 64'(hready_out), 64'd0);
    valid = 1'b0;
    tick();
    chk_state("rd_state_enable", ST_RENABLE);
    check("rd_penable1", 64'(penable), 64'd1);
    check("rd_hready1", 64'(hready_out), 64'd1);
    check("rd_pselx_hold", 64'(pselx), 64'h1);
    tick();
    chk_state("rd_state_idle", ST_IDLE);
    check("rd_idle_pselx", 64'(pselx), 64'd0);
    check("rd_idle_penable", 64'(penable), 64'd0);

    // Single write
    valid = 1'b1; hwrite = 1'b1; haddr = 32'h8400_0020;
    tick();
    chk_state("wr_state_wwait", ST_WWAIT);
    check("wr_wwait_pselx", 64'(pselx), 64'd0);
    check("wr_wwait_hready", 64'(hready_out), 64'd1);
    valid = 1'b0; hwrite = 1'b0; haddr = '0; hwdata = 32'hDEAD_BEEF;
    tick();
    chk_state("wr_state_setup", ST_WRITE);
    check("wr_pselx", 64'(pselx), 64'h2);
    check("wr_paddr", 64'(paddr), 64'h8400_0020);
    check("wr_pwdata", 64'(pwdata), 64'hDEAD_BEEF);
    check("wr_pwrite", 64'(pwrite), 64'd1);
    check("wr_hready0", 64'(hready_out), 64'd0);
    tick();
    chk_state("wr_state_enable", ST_WENABLE);
    check("wr_penable", 64'(penable), 64'd1);
    check("wr_hready1", 64'(hready_out), 64'd1);
    tick();
    chk_state("wr_state_idle", ST_IDLE);
    check("wr_idle_pwrite", 64'(pwrite), 64'd0);

    // Back-to-back writes
    valid = 1'b1; hwrite = 1'b1; haddr = 32'h8800_0000;
    tick();
    chk_state("b2b_wwait", ST_WWAIT);
    haddr = 32'h8800_0004; hwdata = 32'hA5A5_A5A5;
    tick();
    chk_state("b2b_writep", ST_WRITEP);
    check("b2b_paddr0", 64'(paddr), 64'h8800_0000);
    check("b2b_pwdata0", 64'(pwdata), 64'hA5A5_A5A5);
    check("b2b_pselx0", 64'(pselx), 64'h4);
    check("b2b_hready_wp", 64'(hready_out), 64'd0);
    valid = 1'b0; haddr = '0; hwdata = 32'h5A5A_5A5A;
    tick();
    chk_state("b2b_wenablep", ST_WENABLEP);
    check("b2b_penable_p", 64'(penable), 64'd1);
    check("b2b_hready_p", 64'(hready_out), 64'd0);
    hwrite = 1'b0;
    tick();
    chk_state("b2b_write", ST_WRITE);
    check("b2b_paddr1", 64'(paddr), 64'h8800_0004);
    check("b2b_pwdata1", 64'(pwdata), 64'h5A5A_5A5A);
    check("b2b_pselx1", 64'(pselx), 64'h4);
    check("b2b_penable_s", 64'(penable), 64'd0);
    tick();
    chk_state("b2b_wenable", ST_WENABLE);
    check("b2b_hready_e", 64'(hready_out), 64'd1);
    tick();
    chk_state("b2b_idle", ST_IDLE);

    // Write followed by read
    valid = 1'b1; hwrite = 1'b1; haddr = 32'h8400_0100;
    tick();
    chk_state("wr2rd_wwait", ST_WWAIT);
    hwrite = 1'b0; haddr = 32'h8000_0200; hwdata = 32'h1234_5678;
    tick();
    chk_state("wr2rd_writep", ST_WRITEP);
    check("wr2rd_wpaddr", 64'(paddr), 64'h8400_0100);
    check("wr2rd_wpselx", 64'(pselx), 64'h2);
    tick();
    chk_state("wr2rd_wenablep", ST_WENABLEP);
    tick();
    chk_state("wr2rd_read", ST_READ);
    check("wr2rd_paddr", 64'(paddr), 64'h8000_0200);
    check("wr2rd_pselx", 64'(pselx), 64'h1);
    check("wr2rd_pwrite", 64'(pwrite), 64'd0);
    check("wr2rd_pwdata_hold", 64'(pwdata), 64'h1234_5678);
    valid = 1'b0;
    tick();
    chk_state("wr2rd_renable", ST_RENABLE);
    tick();
    chk_state("wr2rd_idle", ST_IDLE);

`ifdef APB_PREADY_EN
    // pready stall in RENABLE
    valid = 1'b1; hwrite = 1'b0; haddr = 32'h8000_0030;
    tick();
    chk_state("rdy_read", ST_READ);
    valid = 1'b0; pready = 1'b0;
    tick();
    chk_state("rdy_renable", ST_RENABLE);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_state("rdy_hold_state", ST_RENABLE);
      check("rdy_hold_penable", 64'(penable), 64'd1);
      check("rdy_hold_hready", 64'(hready_out), 64'd0);
      check("rdy_hold_paddr", 64'(paddr), 64'h8000_0030);
    end
    pready = 1'b1;
    tick();
    chk_state("rdy_release", ST_IDLE);
    check("rdy_release_hready", 64'(hready_out), 64'd1);
    check("rdy_release_penable", 64'(penable), 64'd0);
`endif

    // Reset mid-transfer from WENABLE
    valid = 1'b1; hwrite = 1'b1; haddr = 32'h8800_0040;
    tick();
    valid = 1'b0; hwrite = 1'b0; haddr = '0; hwdata = 32'hCAFE_F00D;
    tick();
    tick();
    chk_state("mid_wenable", ST_WENABLE);
    check("mid_pre_pwdata", 64'(pwdata), 64'hCAFE_F00D);
    hreset = 1'b1;
    tick();
    chk_state("mid_rst_state", ST_IDLE);
    check("mid_rst_penable", 64'(penable), 64'd0);
    check("mid_rst_pselx", 64'(pselx), 64'd0);
    check("mid_rst_hready", 64'(hready_out), 64'd1);
    check("mid_rst_pwrite", 64'(pwrite), 64'd0);
    check("mid_rst_paddr", 64'(paddr), 64'd0);
    check("mid_rst_pwdata", 64'(pwdata), 64'd0);
    hreset = 1'b0;
    tick();
    chk_state("post_rst_idle", ST_IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
